// File: rtl/dreg_pipe.sv
// dreg_pipe: WIDTH-bit data delayed by DEPTH registered stages, each with a valid bit,
// plus stall (en) and synchronous flush. Define DREG_PIPE_OCC_EN to add the occ counter port.
module dreg_pipe #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           q,
`ifdef DREG_PIPE_OCC_EN
    output logic                       q_valid,
    output logic [$clog2(DEPTH+1)-1:0] occ
`else
    output logic                       q_valid
`endif
);

    // d_valid only tags the sample; it never gates shifting. en is the sole advance control,
    // and there is no ready: the consumer stalls the pipe by dropping en.
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
            r_vld <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= RST_VAL;
            end
            r_vld <= '0;
        end else if (en) begin
            r_data[0] <= d;
            r_vld[0]  <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
            end
        end
    end

    assign q       = r_data[DEPTH-1];
    assign q_valid = r_vld[DEPTH-1];

`ifdef DREG_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] r_occ;
    logic             w_occ_inc;
    logic             w_occ_dec;

    // One sample enters and one leaves per en edge, so the count moves by at most one.
    assign w_occ_inc = d_valid & ~r_vld[DEPTH-1];
    assign w_occ_dec = ~d_valid & r_vld[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (en) begin
            if (w_occ_inc) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_occ_dec) begin
                r_occ <= r_occ - OCC_W'(1);
            end
        end
    end

    assign occ = r_occ;
`endif

endmodule

// File: tb/tb_dreg_pipe.sv
// tb_dreg_pipe: randomized and directed checks of dreg_pipe (DEPTH=4) against a queue-based
// delay-line model, plus a DEPTH=1 instance with a non-zero reset value.
module tb_dreg_pipe;
  localparam int W = 8;
  localparam int D = 4;
  localparam logic [W-1:0] RV4 = 8'h00;
  localparam logic [W-1:0] RV1 = 8'h5A;

  logic clk = 1'b0;
  logic rst, en, flush, d_valid;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic q_valid;
  logic en1, flush1, dv1;
  logic [W-1:0] d1;
  logic [W-1:0] q1;
  logic qv1;
`ifdef DREG_PIPE_OCC_EN
  logic [2:0] occ;
  logic [0:0] occ1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: contents of every stage, index 0 = newest, index D-1 = output
  logic [W-1:0] exp_q[$];
  bit exp_v[$];

  // clock / reset block
  always #5 clk = ~clk;

  dreg_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
`ifdef DREG_PIPE_OCC_EN
    .q(q), .q_valid(q_valid), .occ(occ)
`else
    .q(q), .q_valid(q_valid)
`endif
  );

  dreg_pipe #(.WIDTH(W), .DEPTH(1), .RST_VAL(RV1)) u_d1 (
    .clk(clk), .rst(rst), .en(en1), .flush(flush1), .d(d1), .d_valid(dv1),
`ifdef DREG_PIPE_OCC_EN
    .q(q1), .q_valid(qv1), .occ(occ1)
`else
    .q(q1), .q_valid(qv1)
`endif
  );

  function automatic int model_occ();
    int c = 0;
    foreach (exp_v[i]) c += int'(exp_v[i]);
    return c;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_v.delete();
    for (int i = 0; i < D; i++) begin
      exp_q.push_back(RV4);
      exp_v.push_back(1'b0);
    end
  endtask

  // driver: apply one cycle of inputs, update the model at the edge, return at the next negedge
  task automatic drive_edge(input logic e, input logic f, input logic [W-1:0] dd, input logic dv);
    en = e; flush = f; d = dd; d_valid = dv;
    @(posedge clk);
    if (f) begin
      model_clear();
    end else if (e) begin
      exp_q.push_front(dd);
      exp_v.push_front(dv);
      void'(exp_q.pop_back());
      void'(exp_v.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < D; i++) drive_edge(1'b1, 1'b0, W'($urandom_range(1, 255)), 1'b1);
    n_checks++;
    if (q_valid !== 1'b1) begin n_errors++; $display("FAIL reset_prefill_qv: got %b expected 1", q_valid); end
    #2 rst = 1'b1;
    #1;
    model_clear();
    n_checks++;
    if (q !== RV4) begin n_errors++; $display("FAIL reset_q: got %h expected %h", q, RV4); end
    n_checks++;
    if (q_valid !== 1'b0) begin n_errors++; $display("FAIL reset_qv: got %b expected 0", q_valid); end
    n_checks++;
    if (q1 !== RV1) begin n_errors++; $display("FAIL reset_q_d1: got %h expected %h", q1, RV1); end
    n_checks++;
    if (qv1 !== 1'b0) begin n_errors++; $display("FAIL reset_qv_d1: got %b expected 0", qv1); end
`ifdef DREG_PIPE_OCC_EN
    n_checks++;
    if (occ !== 3'd0) begin n_errors++; $display("FAIL reset_occ: got %0d expected 0", occ); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive_edge(1'b1, 1'b0, W'(i), 1'b1);
      n_checks++;
      if (i >= D && (q !== W'(i - D + 1) || q_valid !== 1'b1)) begin
        n_errors++; $display("FAIL stream_out[%0d]: got %h/%b expected %h/1", i, q, q_valid, W'(i - D + 1));
      end else if (i < D && q_valid !== 1'b0) begin
        n_errors++; $display("FAIL stream_fill[%0d]: got qv %b expected 0", i, q_valid);
      end
`ifdef DREG_PIPE_OCC_EN
      n_checks++;
      if (occ !== 3'((i < D) ? i : D)) begin
        n_errors++; $display("FAIL stream_occ[%0d]: got %0d expected %0d", i, occ, (i < D) ? i : D);
      end
`endif
    end
  endtask

  task automatic test_stall();
    drive_edge(1'b0, 1'b1, 8'h00, 1'b0);
    drive_edge(1'b1, 1'b0, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b0, W'($urandom), 1'($urandom));
      n_checks++;
      if (q_valid !== 1'b0 || q !== RV4) begin
        n_errors++; $display("FAIL stall_hold[%0d]: got %h/%b expected %h/0", i, q, q_valid, RV4);
      end
`ifdef DREG_PIPE_OCC_EN
      n_checks++;
      if (occ !== 3'd1) begin n_errors++; $display("FAIL stall_occ[%0d]: got %0d expected 1", i, occ); end
`endif
    end
    for (int i = 1; i < D; i++) begin
      drive_edge(1'b0, 1'b0, 8'h11, 1'b1);
      drive_edge(1'b1, 1'b0, W'($urandom_range(0, 255)), 1'b0);
      n_checks++;
      if (i == D - 1 && (q !== 8'hA5 || q_valid !== 1'b1)) begin
        n_errors++; $display("FAIL stall_emerge: got %h/%b expected a5/1", q, q_valid);
      end else if (i < D - 1 && q_valid !== 1'b0) begin
        n_errors++; $display("FAIL stall_early[%0d]: got qv %b expected 0", i, q_valid);
      end
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] pat_in;
    logic [7:0] pat_out;
    int occ_max;
    pat_in = 8'b0000_1101;  // bit k = d_valid at edge k: 1,0,1,1 then zeros
    pat_out = '0;
    occ_max = 0;
    drive_edge(1'b0, 1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      drive_edge(1'b1, 1'b0, W'($urandom), pat_in[k]);
      pat_out[k] = q_valid;
`ifdef DREG_PIPE_OCC_EN
      if (int'(occ) > occ_max) occ_max = int'(occ);
`endif
    end
    n_checks++;
    if (pat_out !== (pat_in << (D - 1))) begin
      n_errors++; $display("FAIL bubble_pattern: got %b expected %b", pat_out, pat_in << (D - 1));
    end
`ifdef DREG_PIPE_OCC_EN
    n_checks++;
    if (occ_max !== 3) begin n_errors++; $display("FAIL bubble_occ_peak: got %0d expected 3", occ_max); end
`endif
  endtask

  task automatic test_flush();
    for (int i = 0; i < D; i++) drive_edge(1'b1, 1'b0, W'($urandom_range(1, 254)), 1'b1);
    drive_edge(1'b1, 1'b1, 8'hFF, 1'b1);
    n_checks++;
    if (q !== RV4 || q_valid !== 1'b0) begin
      n_errors++; $display("FAIL flush_out: got %h/%b expected %h/0", q, q_valid, RV4);
    end
`ifdef DREG_PIPE_OCC_EN
    n_checks++;
    if (occ !== 3'd0) begin n_errors++; $display("FAIL flush_occ: got %0d expected 0", occ); end
`endif
    for (int i = 0; i < D + 1; i++) begin
      drive_edge(1'b1, 1'b0, W'($urandom_range(0, 254)), 1'b0);
      n_checks++;
      if (q_valid !== 1'b0 || q === 8'hFF) begin
        n_errors++; $display("FAIL flush_lost[%0d]: got %h/%b expected not ff, qv 0", i, q, q_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_edge(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 W'($urandom), 1'($urandom));
      n_checks++;
      if (q !== exp_q[D-1] || q_valid !== exp_v[D-1]) begin
        n_errors++; $display("FAIL random_out[%0d]: got %h/%b expected %h/%b", i, q, q_valid, exp_q[D-1], exp_v[D-1]);
      end
`ifdef DREG_PIPE_OCC_EN
      n_checks++;
      if (int'(occ) !== model_occ()) begin
        n_errors++; $display("FAIL random_occ[%0d]: got %0d expected %0d", i, occ, model_occ());
      end
`endif
    end
  endtask

  task automatic test_depth1();
    en1 = 1'b1; flush1 = 1'b0; d1 = 8'h3C; dv1 = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (q1 !== 8'h3C || qv1 !== 1'b1) begin n_errors++; $display("FAIL d1_load: got %h/%b expected 3c/1", q1, qv1); end
    en1 = 1'b0; d1 = 8'h77; dv1 = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (q1 !== 8'h3C || qv1 !== 1'b1) begin n_errors++; $display("FAIL d1_hold: got %h/%b expected 3c/1", q1, qv1); end
    en1 = 1'b1; flush1 = 1'b1; d1 = 8'h99; dv1 = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (q1 !== RV1 || qv1 !== 1'b0) begin n_errors++; $display("FAIL d1_flush: got %h/%b expected %h/0", q1, qv1, RV1); end
    en1 = 1'b0; flush1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
    en1 = 1'b0; flush1 = 1'b0; d1 = '0; dv1 = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_streaming();
    test_stall();
    test_bubbles();
    test_flush();
    test_random();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dreg_pipe.md
# dreg_pipe

Parametrised D-register pipeline: a WIDTH-bit data path delayed by DEPTH flip-flop stages, each stage carrying a valid bit, with global advance-enable (stall) and synchronous flush. It generalises the single-bit clocked D register into the standard delay/alignment element for datapaths in this codebase. It is used wherever a bus must be retimed by a fixed number of qualified cycles while tracking which stages hold live data.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1; DEPTH=1 is an enabled D register with valid)
- RST_VAL, 0, WIDTH-bit value loaded into every data stage on reset and flush

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  advance enable; 0 = all stages hold
- flush  input  1  synchronous clear of all stages
- d  input  WIDTH  data into stage 0
- d_valid  input  1  valid qualifier for d
- q  output  WIDTH  data of stage DEPTH-1 (registered)
- q_valid  output  1  valid bit of stage DEPTH-1 (registered)
- occ  output  $clog2(DEPTH+1)  count of valid stages (only with DREG_PIPE_OCC_EN)

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1].
- rst=1 (any time, independent of clk): data[i]=RST_VAL, vld[i]=0, occ=0 immediately; q=RST_VAL, q_valid=0.
- Priority at each rising edge with rst=0: flush > en > hold.
- flush=1: data[i]<=RST_VAL, vld[i]<=0, occ<=0; en, d, d_valid ignored that cycle.
- flush=0, en=1: data[0]<=d, vld[0]<=d_valid; data[i]<=data[i-1], vld[i]<=vld[i-1] for i=1..DEPTH-1. Data shifts regardless of valid (invalid bubbles carry whatever d held).
- flush=0, en=0: every register holds; d/d_valid dropped.
- q=data[DEPTH-1], q_valid=vld[DEPTH-1]; no combinational path from any input to q/q_valid.
- occ (if enabled): registered counter, occ<=occ+d_valid−vld[DEPTH-1] on en edges; always equals popcount(vld). Never exceeds DEPTH, never underflows.
- Bubbles: d_valid=0 on an en edge inserts an invalid stage; pattern of valids is preserved exactly through the pipe.

## Timing
- Latency: a sample presented with en=1 at edge k appears at q/q_valid after edge k+DEPTH−1, i.e. visible DEPTH en-qualified edges later; non-en edges do not count.
- Throughput: one sample per en edge, no back-pressure output (consumer must use en as stall).
- Reset deassertion: first state update at the first rising edge after rst falls; rst release need not be synchronised internally (integrator provides synchronised deassert).
- Simultaneous flush and en: flush wins, pipe empty next cycle, input sample lost.
- Reset asserted mid-operation: all in-flight samples discarded, no partial shift.

## Configuration
- DREG_PIPE_OCC_EN defined: occ port and occupancy counter present as above.
- Not defined: occ port and counter removed; all other behaviour identical, cycle for cycle.

## Test plan
- Reset: drive rst=1 mid-cycle with vld all 1 -> q=RST_VAL, q_valid=0, occ=0 before next clk edge.
- Streaming: WIDTH=8, DEPTH=4, en=1, d=0x01..0x08 valid each cycle -> q=0x01 with q_valid=1 exactly 4 edges after first load, then 0x02..0x08 consecutively; occ ramps 1,2,3,4 and holds 4.
- Stall: load 0xA5 then en=0 for 3 cycles -> q/q_valid/occ frozen; after en=1 resumes, 0xA5 emerges after remaining stage count of en edges only.
- Bubbles: d_valid pattern 1,0,1,1 with en=1 -> q_valid pattern 1,0,1,1 DEPTH edges later; occ peaks at 3.
- Flush priority: pipe holding 4 valid samples, flush=1 and en=1 with d=0xFF, d_valid=1 -> next cycle q_valid=0, q=RST_VAL, occ=0, 0xFF never appears.
- DEPTH=1, OCC disabled build: en=1 d=0x3C valid -> q=0x3C, q_valid=1 after one edge; elaborates without occ port.
